// File: rtl/keypad_pkg.sv
// Shared constants, scan state encoding and key-image helpers
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NROW  = 4;
  localparam int NCOL  = 4;
  localparam int IMG_W = NROW * NCOL;

  typedef enum logic [1:0] {
    S_DRIVE0,
    S_DRIVE1,
    S_DRIVE2,
    S_DRIVE3
  } scan_state_e;

  // Indexed by image bit 4*col+row, row0 at the top.
  localparam logic [3:0] KEY_MAP [IMG_W] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic is_single(
    input logic [IMG_W-1:0] img
  );
    return (img != '0) &&
           ((img & (img - IMG_W'(1))) == '0);
  endfunction

  function automatic logic [3:0] key_of(
    input logic [IMG_W-1:0] img
  );
    logic [3:0] k;
    k = '0;
    for (int i = IMG_W - 1; i >= 0; i--) begin
      if (img[i]) k = KEY_MAP[i];
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-image debouncer: the image must repeat DEB_SCANS
// times in a row before it replaces the debounced image.
module keypad_debounce #(
  parameter int W         = 16,
  parameter int DEB_SCANS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] image,
  input  logic         strobe,
  output logic [W-1:0] debounced,
  output logic         update
);

  localparam int SW = $clog2(DEB_SCANS + 1);
  localparam logic [SW-1:0] SMAX = SW'(DEB_SCANS);

  logic [W-1:0]  prev_q, prev_d;
  logic [W-1:0]  deb_q, deb_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          load_q, load_d;
  logic          upd_q, upd_d;

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    load_d   = 1'b0;
    upd_d    = load_q;
    if (load_q) deb_d = prev_q;
    if (strobe) begin
      if (image == prev_q) begin
        // Load fires only on the step into SMAX, not while saturated
        if (stable_q != SMAX) begin
          stable_d = stable_q + SW'(1);
          load_d   = (stable_d == SMAX);
        end
      end else begin
        stable_d = '0;
        prev_d   = image;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      deb_q    <= '0;
      stable_q <= '0;
      load_q   <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      deb_q    <= deb_d;
      stable_q <= stable_d;
      load_q   <= load_d;
      upd_q    <= upd_d;
    end
  end

  assign debounced = deb_q;
  assign update    = upd_q;

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 active-low keypad scanner with debounce, single-key
// press events and a four-digit hex entry shift register.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int CPS       = 25000,
  parameter int DEB_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  input  logic        clear,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] entry_value
);

  localparam int CW = $clog2(CPS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CPS - 1);

  logic [NROW-1:0]  row_s1_q, row_s1_d;
  logic [NROW-1:0]  row_s2_q, row_s2_d;

  scan_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NCOL-1:0]  col_n_q, col_n_d;
  logic [IMG_W-1:0] scan_q, scan_d;
  logic             scan_end_q, scan_end_d;
  logic             wrap;
  logic [1:0]       col_idx;

  logic [IMG_W-1:0] deb;
  logic             deb_upd;
  logic [IMG_W-1:0] deb_last_q, deb_last_d;
  logic             evt;

  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_held_q, key_held_d;
  logic [15:0]      entry_q, entry_d;

  always_comb begin
    row_s1_d = row_n;
    row_s2_d = row_s1_q;
  end

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      state_q    <= S_DRIVE0;
      cnt_q      <= '0;
      col_n_q    <= 4'b1110;
      scan_q     <= '0;
      scan_end_q <= 1'b0;
    end else begin
      row_s1_q   <= row_s1_d;
      row_s2_q   <= row_s2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_n_q    <= col_n_d;
      scan_q     <= scan_d;
      scan_end_q <= scan_end_d;
    end
  end

  // Scan FSM: next state
  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    if (wrap) begin
      cnt_d   = '0;
      state_d = scan_state_e'(2'(state_q + 2'd1));
    end
  end

  // Scan FSM: outputs
  always_comb begin
    col_idx    = state_q;
    col_n_d    = col_n_q;
    scan_d     = scan_q;
    scan_end_d = 1'b0;
    if (wrap) begin
      col_n_d = ~(4'b0001 << state_d);
      scan_d[{col_idx, 2'b00} +: NROW] = ~row_s2_q;
      scan_end_d = (state_q == S_DRIVE3);
    end
  end

  keypad_debounce #(
    .W         (IMG_W),
    .DEB_SCANS (DEB_SCANS)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .image     (scan_q),
    .strobe    (scan_end_q),
    .debounced (deb),
    .update    (deb_upd)
  );

  // A press counts only when leaving the all-released image
  always_comb begin
    evt         = deb_upd && (deb_last_q == '0) && is_single(deb);
    deb_last_d  = deb;
    key_valid_d = evt;
    key_code_d  = key_code_q;
    key_held_d  = |deb;
    entry_d     = entry_q;
    if (evt) begin
      key_code_d = key_of(deb);
      entry_d    = {entry_q[11:0], key_of(deb)};
    end
    if (clear) entry_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_last_q  <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      entry_q     <= '0;
    end else begin
      deb_last_q  <= deb_last_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      entry_q     <= entry_d;
    end
  end

  assign col_n       = col_n_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_held    = key_held_q;
  assign entry_value = entry_q;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Directed bench for keypad_scanner_4x4 with a behavioural
// keypad that pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner_4x4;

  localparam int CPS  = 4;
  localparam int DEB  = 2;
  localparam int SCAN = 4 * CPS;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] entry_value;

  logic [15:0] pressed;
  int compared = 0;
  int mism     = 0;
  int pulses   = 0;

  keypad_scanner_4x4 #(
    .CPS       (CPS),
    .DEB_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_n       (row_n),
    .col_n       (col_n),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_held    (key_held),
    .entry_value (entry_value)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[4*c+r] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid) pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tap(input int bitn, input int n);
    pressed = 16'(1) << bitn;
    scans(n);
    pressed = '0;
    scans(n);
  endtask

  initial begin
    int p;
    int found;
    logic [3:0] prev_col;
    int keys [4] = '{0, 4, 8, 12};

    rst = 1'b1; clear = 1'b0; pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_entry", entry_value, 16'h0000);
    chk("rst_code", key_code, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("col0_hold", col_n, 4'b1110);
    @(posedge clk);
    @(negedge clk);
    chk("col1_step", col_n, 4'b1101);

    p = pulses;
    pressed = 16'(1) << 5;
    scans(8);
    chk("k5_pulses", pulses, p + 1);
    chk("k5_code", key_code, 4'h5);
    chk("k5_entry", entry_value, 16'h0005);
    chk("k5_held", key_held, 1);
    scans(20);
    chk("k5_norepeat", pulses, p + 1);
    pressed = '0;
    scans(6);
    chk("k5_release", key_held, 0);

    p = pulses;
    for (int i = 0; i < 4; i++) tap(keys[i], 6);
    chk("seq_pulses", pulses, p + 4);
    chk("seq_entry", entry_value, 16'h123A);

    p = pulses;
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? (16'(1) << 2) : 16'h0;
      scans(1);
    end
    chk("bounce_none", pulses, p);
    pressed = 16'(1) << 2;
    scans(8);
    chk("k7_pulses", pulses, p + 1);
    chk("k7_code", key_code, 4'h7);
    pressed = '0;
    scans(6);
    chk("k7_entry", entry_value, 16'h23A7);

    p = pulses;
    pressed = 16'h0011;
    scans(8);
    chk("two_none", pulses, p);
    chk("two_held", key_held, 1);
    pressed = 16'h0010;
    scans(8);
    chk("one_left_none", pulses, p);
    chk("one_left_held", key_held, 1);
    pressed = '0;
    scans(6);
    chk("all_up_held", key_held, 0);
    pressed = 16'h0010;
    scans(8);
    chk("k2_pulses", pulses, p + 1);
    chk("k2_code", key_code, 4'h2);
    chk("k2_entry", entry_value, 16'h3A72);
    pressed = '0;
    scans(6);

    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("clear_entry", entry_value, 16'h0000);
    tap(0, 6);
    tap(4, 6);
    chk("pre_clr_entry", entry_value, 16'h0012);

    p = pulses;
    found = 0;
    prev_col = col_n;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (prev_col == 4'b0111 && col_n == 4'b1110) begin
        found = 1;
        break;
      end
      prev_col = col_n;
    end
    chk("scan_start", found, 1);
    pressed = 16'(1) << 10;
    repeat (50) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("clr_evt_valid", key_valid, 1);
    chk("clr_evt_code", key_code, 4'h9);
    chk("clr_evt_entry", entry_value, 16'h0000);
    @(negedge clk);
    chk("clr_evt_one", key_valid, 0);
    chk("clr_evt_entry2", entry_value, 16'h0000);

    scans(8);
    chk("k9_norepeat", pulses, p + 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_col", col_n, 4'b1110);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_entry", entry_value, 16'h0000);
    rst = 1'b0;
    p = pulses;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("requal_held", key_held, 0);
    chk("requal_none", pulses, p);
    scans(8);
    chk("requal_pulse", pulses, p + 1);
    chk("requal_code", key_code, 4'h9);
    chk("requal_entry", entry_value, 16'h0009);
    chk("requal_held2", key_held, 1);
    pressed = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
